// File: rtl/d_sram_to_sram_like_pkg.sv
// Shared types for the data-side sram -> sram-like bridge: FSM state encoding,
// sram-like transfer size codes and a word-alignment helper.
package d_sram_to_sram_like_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    DONE      = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/d_sram_to_sram_like_size_enc.sv
// Combinational size/address encoder: turns byte write strobes into an
// sram-like transfer size, the address to present and the write flag.
module d_size_enc
  import d_sram_to_sram_like_pkg::*;
(
  input  logic [3:0]  wen_i,
  input  logic [31:0] addr_i,
  output logic [1:0]  size_o,
  output logic [31:0] addr_o,
  output logic        wr_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    wr_o   = |wen_i;
    size_o = SIZE_W;
    addr_o = addr_i;
    case (wen_i)
      4'b0000:                            addr_o = word_align(addr_i);
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = SIZE_B;
      4'b0011, 4'b1100:                   size_o = SIZE_H;
      4'b1111:                            size_o = SIZE_W;
      // Non-contiguous strobes fall back to an aligned full-word write.
      default:                            addr_o = word_align(addr_i);
    endcase
  end

endmodule

// File: rtl/d_sram_to_sram_like.sv
// Data-side bridge from the core's sram port to an sram-like bus with a
// 3-state handshake FSM. Optional macro D_ADDR_MAP_EN folds kseg0/kseg1 to physical.
module d_sram_to_sram_like
  import d_sram_to_sram_like_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        longest_stall,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  state_e      state_q;
  logic [31:0] rdata_q;
  logic [31:0] enc_addr;

  d_size_enc u_size_enc (
    .wen_i  (data_sram_wen),
    .addr_i (data_sram_addr),
    .size_o (data_size),
    .addr_o (enc_addr),
    .wr_o   (data_wr)
  );

`ifdef D_ADDR_MAP_EN
  assign data_addr = (enc_addr[31:30] == 2'b10) ? {3'b000, enc_addr[28:0]} : enc_addr;
`else
  assign data_addr = enc_addr;
`endif

  assign data_wdata      = data_sram_wdata;
  assign data_sram_rdata = rdata_q;

  // Reset masks the handshake outputs so nothing leaks to the bus mid-reset.
  assign data_req = ~rst & (state_q == IDLE) & data_sram_en;
  assign d_stall  = ~rst & (((state_q == IDLE) & data_sram_en) | (state_q == WAIT_DATA));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE:      if (data_req && data_addr_ok) state_q <= WAIT_DATA;
        WAIT_DATA: if (data_data_ok) begin
                     rdata_q <= data_rdata;
                     state_q <= DONE;
                   end
        DONE:      if (!longest_stall) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Self-checking bench for d_sram_to_sram_like: directed scenarios followed by
// randomized core/interconnect traffic, checked by a scoreboard monitor.
module tb_d_sram_to_sram_like;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        longest_stall, d_stall;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;

  always #5 clk = ~clk;

  d_sram_to_sram_like dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .longest_stall   (longest_stall),
    .d_stall         (d_stall),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_rdata      (data_rdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rsp_q[$];

  // Reference: what the bus should see for a given core access.
  function automatic req_t model(input logic [3:0] wen, input logic [31:0] addr,
                                 input logic [31:0] wdata);
    req_t r;
    int   n;
    n       = $countones(wen);
    r.wr    = (n != 0);
    r.wdata = wdata;
    r.addr  = addr;
    r.size  = 2'd2;
    if (n == 0)                             r.addr = addr - (addr % 4);
    else if (n == 1)                        r.size = 2'd0;
    else if (wen == 4'b0011 || wen == 4'b1100) r.size = 2'd1;
    else if (wen != 4'b1111)                r.addr = addr - (addr % 4);
`ifdef D_ADDR_MAP_EN
    if (r.addr >= 32'h8000_0000 && r.addr <= 32'hBFFF_FFFF) r.addr = r.addr & 32'h1FFF_FFFF;
`endif
    return r;
  endfunction

  // Interconnect model knobs and state.
  int          ao_pct = 100, dly_min = 1, dly_max = 1, spur_pct = 0, cnt = 0;
  logic        fixed_en = 1'b0;
  logic [31:0] fixed_rdata = '0;
  logic        dok_real = 1'b0;
  logic        mon_en = 1'b0;

  logic        s_stall, s_req, s_wr, s_ls;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_rdata;

  // One bus cycle: sample DUT at negedge, then drive the interconnect after the edge.
  task automatic cycle();
    @(negedge clk);
    s_stall = d_stall;   s_req = data_req;   s_addr = data_addr;
    s_size  = data_size; s_wr  = data_wr;    s_rdata = data_sram_rdata;
    s_ls    = longest_stall;
    if (rst) cnt = 0;
    else if (data_req && data_addr_ok) cnt = $urandom_range(dly_max, dly_min);
    @(posedge clk);
    #1;
    data_data_ok = 1'b0;
    dok_real     = 1'b0;
    data_rdata   = $urandom;
    if (cnt == 1) begin
      data_data_ok = 1'b1;
      dok_real     = 1'b1;
      if (fixed_en) data_rdata = fixed_rdata;
      rsp_q.push_back(data_rdata);
    end else if (cnt == 0 && $urandom_range(99, 0) < spur_pct) begin
      data_data_ok = 1'b1;
    end
    if (cnt > 0) cnt--;
    data_addr_ok = ($urandom_range(99, 0) < ao_pct);
  endtask

  task automatic issue(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    if (en) req_q.push_back(model(wen, addr, wdata));
  endtask

  task automatic run_to_done(input string name);
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (!s_stall) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: d_stall still high after 50 cycles, expected low", name);
  endtask

  // Monitor: compares every accepted request and the result register against the model.
  initial begin
    logic [31:0] exp_rd, h_addr;
    logic [1:0]  h_size;
    logic        hold;
    req_t        r;
    exp_rd = '0;
    hold   = 1'b0;
    h_addr = '0;
    h_size = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("rdata_hold", data_sram_rdata, exp_rd);
        if (rst) begin
          check("rst_req", data_req, 1'b0);
          check("rst_stall", d_stall, 1'b0);
        end
        if (hold && !rst) begin
          check("held_req", data_req, 1'b1);
          check("held_addr", data_addr, h_addr);
          check("held_size", data_size, h_size);
        end
        if (data_req && data_addr_ok) begin
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got request addr 0x%08h, expected none", data_addr);
          end else begin
            r = req_q.pop_front();
            check("req_addr", data_addr, r.addr);
            check("req_size", data_size, r.size);
            check("req_wr", data_wr, r.wr);
            check("req_wdata", data_wdata, r.wdata);
          end
        end
        if (data_data_ok && dok_real && rsp_q.size() != 0) exp_rd = rsp_q.pop_front();
        if (rst) exp_rd = '0;
        hold   = data_req && !data_addr_ok && !rst;
        h_addr = data_addr;
        h_size = data_size;
      end
    end
  end

  initial begin
    rst = 1'b1; longest_stall = 1'b0;
    data_sram_en = 1'b1; data_sram_wen = '0; data_sram_addr = 32'h1000; data_sram_wdata = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;

    // Reset with the core asserting enable.
    cycle();
    check("rst0_req", s_req, 1'b0);
    check("rst0_stall", s_stall, 1'b0);
    cycle();
    check("rst0_rdata", s_rdata, 32'h0);
    rst = 1'b0;
    data_sram_en = 1'b0;
    mon_en = 1'b1;

    // Minimum-latency read.
    fixed_en = 1'b1; fixed_rdata = 32'h1234_5678;
    issue(1'b1, 4'b0000, 32'h0000_1006, 32'h0);
    cycle();
    check("rd_stall_c0", s_stall, 1'b1);
    check("rd_addr", s_addr, 32'h0000_1004);
    check("rd_size", s_size, 2'd2);
    check("rd_wr", s_wr, 1'b0);
    cycle();
    check("rd_stall_c1", s_stall, 1'b1);
    check("rd_req_c1", s_req, 1'b0);
    cycle();
    check("rd_stall_c2", s_stall, 1'b0);
    check("rd_rdata", s_rdata, 32'h1234_5678);

    // Store byte with addr_ok withheld for three cycles.
    ao_pct = 0; data_addr_ok = 1'b0;
    fixed_rdata = 32'hCAFE_0001;
    issue(1'b1, 4'b0100, 32'h0000_2002, 32'hAABB_CCDD);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ao_pct = 100;
      cycle();
      check("sb_req_held", s_req, 1'b1);
      check("sb_addr", s_addr, 32'h0000_2002);
      check("sb_size", s_size, 2'd0);
      check("sb_wr", s_wr, 1'b1);
      check("sb_stall", s_stall, 1'b1);
    end
    run_to_done("sb_done");

    // Store half.
    issue(1'b1, 4'b1100, 32'h0000_2002, 32'h1122_0000);
    cycle();
    check("sh_size", s_size, 2'd1);
    check("sh_addr", s_addr, 32'h0000_2002);
    run_to_done("sh_done");

    // Global freeze for four cycles in DONE.
    fixed_rdata = 32'hCAFE_0002;
    longest_stall = 1'b1;
    issue(1'b1, 4'b0000, 32'h0000_3008, 32'h0);
    run_to_done("ls_done");
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("ls_req", s_req, 1'b0);
      check("ls_stall", s_stall, 1'b0);
      check("ls_rdata", s_rdata, 32'hCAFE_0002);
    end
    longest_stall = 1'b0;
    cycle();
    check("ls_fall_req", s_req, 1'b0);
    issue(1'b1, 4'b0000, 32'h0000_4000, 32'h0);
    cycle();
    check("ls_idle_req", s_req, 1'b1);
    run_to_done("ls_next_done");

    // Enable dropped while waiting for data.
    dly_min = 3; dly_max = 3; fixed_rdata = 32'hCAFE_0003;
    issue(1'b1, 4'b0000, 32'h0000_5000, 32'h0);
    cycle();
    data_sram_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("flush_stall", s_stall, 1'b1);
    end
    cycle();
    check("flush_stall_end", s_stall, 1'b0);
    check("flush_rdata", s_rdata, 32'hCAFE_0003);

    // Reset while waiting for data; a late data_ok must be ignored.
    dly_min = 5; dly_max = 5;
    issue(1'b1, 4'b0000, 32'h0000_6000, 32'h0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    data_sram_en = 1'b0;
    cycle();
    check("rstw_stall", s_stall, 1'b0);
    check("rstw_rdata", s_rdata, 32'h0);
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    cycle();
    cycle();
    check("late_ok_rdata", s_rdata, 32'h0);
    check("late_ok_stall", s_stall, 1'b0);
    dly_min = 1; dly_max = 1;

    // kseg1 read address.
    issue(1'b1, 4'b0000, 32'hBFC0_0010, 32'h0);
    cycle();
`ifdef D_ADDR_MAP_EN
    check("map_addr", s_addr, 32'h1FC0_0010);
`else
    check("map_addr", s_addr, 32'hBFC0_0010);
`endif
    run_to_done("map_done");

    // Randomized traffic.
    fixed_en = 1'b0; spur_pct = 15; dly_min = 1; dly_max = 4; ao_pct = 60;
    data_sram_en = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cycle();
      if (!s_stall && !s_ls) begin
        logic [3:0] w;
        w = ($urandom_range(1, 0) == 0) ? 4'b0000 : 4'($urandom);
        issue($urandom_range(4, 0) != 0, w, $urandom, $urandom);
      end
      longest_stall = ($urandom_range(3, 0) == 0);
    end
    longest_stall = 1'b0;
    run_to_done("drain");
    data_sram_en = 1'b0;
    cycle();
    cycle();
    check("req_q_empty", req_q.size(), 32'd0);
    check("rsp_q_empty", rsp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_sram_to_sram_like.md
D_SRAM_TO_SRAM_LIKE -- requirements
Module: d_sram_to_sram_like

Interface
REQ-001 Parameter: none; all widths are fixed.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 data_sram_en  in  1  memory-stage access enable (mem_enM).
REQ-005 data_sram_wen  in  4  byte write strobes (selectM); 0 means read.
REQ-006 data_sram_addr  in  32  byte address (aluoutM).
REQ-007 data_sram_wdata  in  32  lane-aligned store data.
REQ-008 data_sram_rdata  out  32  full word returned to the core (readdataM).
REQ-009 longest_stall  in  1  global pipeline freeze from hazard unit.
REQ-010 d_stall  out  1  data-side stall to hazard unit (dataStall).
REQ-011 data_req, data_wr  out  1 each  sram-like request valid; write flag.
REQ-012 data_size  out  2  0=byte, 1=half, 2=word.
REQ-013 data_addr, data_wdata  out  32 each  sram-like address and write data.
REQ-014 data_rdata  in  32; data_addr_ok, data_data_ok  in  1 each  sram-like responses.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT_DATA and DONE.
REQ-016 In IDLE: data_req = data_sram_en; on data_req & data_addr_ok, move to WAIT_DATA; otherwise stay.
REQ-017 In WAIT_DATA: data_req = 0; on data_data_ok, capture data_rdata into the result register and move to DONE.
REQ-018 In DONE: data_req = 0; if ~longest_stall, move to IDLE; otherwise hold DONE and the result.
REQ-019 d_stall = (IDLE & data_sram_en) | WAIT_DATA; it is combinational and 0 in DONE.
REQ-020 data_sram_rdata SHALL be the result register, which updates only on the WAIT_DATA data_ok capture.
REQ-021 data_wr = |data_sram_wen; data_wdata = data_sram_wdata, passed unchanged.
REQ-022 Write size and address:
- wen 0001/0010/0100/1000: size 0, address unchanged.
- wen 0011/1100: size 1, address unchanged.
- wen 1111: size 2.
- Any other nonzero wen: size 2, address forced word-aligned.
REQ-023 Reads SHALL use size 2 with address {addr[31:2],2'b00}; the core performs byte/half extraction.
REQ-024 Minimum latency: addr_ok in cycle 0, data_ok in cycle 1, d_stall low in cycle 2, giving 2 stall cycles.
REQ-025 data_data_ok in IDLE or DONE SHALL be ignored.
REQ-026 If data_sram_en drops in WAIT_DATA (exception flush), the block SHALL still wait for data_data_ok and keep d_stall high.
REQ-027 Held request: while IDLE and ~data_addr_ok, data_req, address, size and wdata SHALL stay stable given stable inputs.

Reset
REQ-028 On rst, the state SHALL become IDLE and the result register SHALL become 0, on the clk edge.
REQ-029 During reset, data_req=0 and d_stall=0 regardless of data_sram_en.
REQ-030 Reset mid-transaction SHALL abandon it; the interconnect is reset by the same rst.

Configuration
REQ-031 Macro D_ADDR_MAP_EN:
- Defined: addresses 0x8000_0000-0xBFFF_FFFF SHALL have bits [31:29] cleared on data_addr; other addresses pass through.
- Undefined: data_addr equals the encoded address with no mapping.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=2'd0, WAIT_DATA=2'd1, DONE=2'd2) and the size codes SIZE_B/SIZE_H/SIZE_W.
REQ-033 One sub-module, d_size_enc, SHALL be combinational: wen and addr in; size, aligned addr and wr out.

Verification
REQ-034 Read, addr=0x0000_1006, wen=0, addr_ok at cycle 0, data_ok+rdata=0x1234_5678 at cycle 1 -> data_addr=0x0000_1004, size=2, d_stall high for 2 cycles, data_sram_rdata=0x1234_5678.
REQ-035 Store byte, wen=0100, addr=0x0000_2002 -> data_wr=1, size=0, data_addr=0x0000_2002; store half, wen=1100 -> size=1.
REQ-036 addr_ok withheld for 3 cycles -> data_req stays high with stable addr; d_stall high until DONE.
REQ-037 longest_stall high for 4 cycles after DONE -> no new data_req, rdata held, d_stall=0; IDLE one cycle after longest_stall falls.
REQ-038 rst asserted in WAIT_DATA -> IDLE and rdata=0 next edge; a late data_ok is ignored.
REQ-039 With D_ADDR_MAP_EN, read at 0xBFC0_0010 -> data_addr=0x1FC0_0010; without it -> data_addr=0xBFC0_0010.
